spi_deserializer: RTL and testbench
===================================

Name: spi_deserializer

Overview:
- Receive-side companion to the SPI address serializer. It observes the same n_cs/spi_clk pair the serializer drives and samples miso.
- It discards the command/address phase, then shifts incoming miso bits MSB-first into DATAW-bit words.
- Words are presented on a valid/ready output interface with one word of buffering. Overflow and truncated words are flagged on err.
- Sits between the SPI pads and the downstream data consumer, in the same clk domain as the serializer.

Parameters:
- DATAW, 8: width of each received word, in bits; must be ≥ 2.
- SKIPBITS, 32: number of spi_clk rising edges ignored after n_cs falls (8 command + 24 address bits); 0 means no skip phase.
- CNTW, $clog2(SKIPBITS+DATAW+1): internal counter width; derived, do not override.

Ports:
- clk, input, 1: system clock; spi_clk and n_cs are generated synchronously to it.
- rst, input, 1: synchronous active-high reset.
- n_cs, input, 1: SPI chip select, active-low, from the serializer.
- spi_clk, input, 1: SPI clock, from the serializer.
- miso, input, 1: serial data from the flash.
- data_out, output, DATAW: received word, MSB = first bit received.
- valid_out, output, 1: data_out holds an unconsumed word.
- ready_in, input, 1: consumer accepts the word when valid_out && ready_in.
- err, output, 1: sticky error flag (overflow or truncated word).

Behaviour:
- Reset (rst=1 at a clk edge):
  - data_out=0, valid_out=0, err=0; state=IDLE; counters=0; shift register=0.
  - Edge-detect registers load sclk_q=0 and ncs_q=1.
  - Reset wins over every other event in the same cycle.
- Edge detection:
  - sclk_q and ncs_q register spi_clk and n_cs each clk.
  - rise = spi_clk & ~sclk_q.
  - cs_fall = ~n_cs & ncs_q.
  - cs_rise = n_cs & ~ncs_q.
  - miso is sampled in the same clk cycle that rise is true.
- State machine:
  - IDLE: wait for cs_fall. On cs_fall, clear err and the counters; go to SKIP, or to DATA if SKIPBITS=0.
  - SKIP: each rise increments skip_cnt and miso is ignored. When the rise makes skip_cnt reach SKIPBITS, go to DATA.
  - DATA: each rise shifts miso into the LSB of the shift register and increments bit_cnt. On the rise where bit_cnt reaches DATAW, a word is complete: set bit_cnt=0 and stay in DATA.
  - Any state: cs_rise returns the FSM to IDLE.
- cs_rise rules:
  - cs_rise in SKIP: no output and no err.
  - cs_rise in DATA with 0 < bit_cnt < DATAW: partial word discarded, err=1.
  - cs_rise with bit_cnt=0: clean end of transaction, no err.
- Word completion and latency:
  - The completed word (previous DATAW-1 bits plus the current miso) appears on data_out with valid_out=1 on the clk edge after the completing rise (1-cycle latency).
- Handshake:
  - valid_out holds and data_out stays stable until valid_out && ready_in.
  - The cycle after acceptance, valid_out=0 unless a new word loads in that same cycle.
- Simultaneous accept and new word: if a word completes in the cycle where valid_out && ready_in, the new word loads, valid_out stays 1 and err is unaffected.
- Overflow: if a word completes while valid_out=1 and ready_in=0, the new word is dropped, data_out keeps the old word, and err=1.
- err is sticky; it clears only on rst or on the next cs_fall.
- Ignored inputs: rise events while n_cs=1 (IDLE) have no effect, and miso is don't-care outside DATA.
- Reset mid-transaction: all state clears immediately. Reception restarts only on a fresh cs_fall, i.e. n_cs must be seen high and then low after reset.
- Word boundaries: words never straddle transactions; bit_cnt restarts at 0 on every cs_fall.

Test Plan:
1. Nominal transaction: DATAW=8, SKIPBITS=32, ready_in=1. Drive n_cs low, 32 skip bits of arbitrary miso, then bits of 0xA5 and 0x3C, then n_cs high. Required: exactly two valid_out pulses, data_out=0xA5 then 0x3C, each one clk after the 8th rise; err=0.
2. Backpressure/overflow: ready_in=0 throughout, send 0x11, 0x22, 0x33. Required: data_out=0x11 held with valid_out=1, err=1 after the 0x22 completion. Then raise ready_in: one transfer of 0x11, after which valid_out=0.
3. Simultaneous accept: ready_in pulsed high exactly in the cycle 0x22 completes while 0x11 is pending. Required: 0x11 accepted, data_out=0x22, valid_out stays 1, err=0.
4. Truncated word: n_cs rises after 5 data bits. Required: no valid_out, err=1. The next cs_fall clears err, and a following full 0x5A is received correctly.
5. Abort in skip phase: n_cs rises after 20 of 32 skip bits. Required: no valid_out, err=0, FSM back in IDLE.
6. Reset mid-word: rst=1 for one cycle after 4 data bits. Required: valid_out=0, data_out=0, err=0 next cycle. Edges with n_cs still low produce no words until n_cs toggles high then low.

Source files
------------

// File: rtl/spi_deserializer.sv
// SPI receive path: skips the command/address phase after n_cs falls, then
// packs miso bits MSB-first into DATAW-bit words behind a one-entry valid/ready buffer.
module spi_deserializer #(
  parameter int DATAW    = 8,
  parameter int SKIPBITS = 32,
  parameter int CNTW     = $clog2(SKIPBITS + DATAW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             n_cs,
  input  logic             spi_clk,
  input  logic             miso,
  output logic [DATAW-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             err,
  output logic [1:0]       fsm_state
);

  // Handshake: a word is transferred on every clk edge where valid_out && ready_in;
  // while valid_out is high, data_out is held stable and valid_out only drops
  // after such a transfer (unless a new word loads in that same cycle).

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SKIP = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  localparam logic [CNTW-1:0] SKIP_LAST = CNTW'((SKIPBITS == 0) ? 0 : SKIPBITS - 1);
  localparam logic [CNTW-1:0] DATA_LAST = CNTW'(DATAW - 1);

  logic [1:0]       state;
  logic             sclk_q;
  logic             ncs_q;
  logic             armed;
  logic [CNTW-1:0]  skip_cnt;
  logic [CNTW-1:0]  bit_cnt;
  logic [DATAW-2:0] shift_reg;

  logic             rise;
  logic             cs_fall;
  logic             cs_rise;
  logic             word_done;
  logic             accept;
  logic [DATAW-1:0] next_word;

  // armed blocks the fake falling edge seen right after a reset taken with n_cs
  // already low: a transaction only starts once n_cs has been observed high.
  assign rise      = spi_clk & ~sclk_q;
  assign cs_fall   = ~n_cs & ncs_q & armed;
  assign cs_rise   = n_cs & ~ncs_q;
  assign next_word = {shift_reg, miso};
  assign word_done = (state == DATA) && rise && !cs_rise && (bit_cnt == DATA_LAST);
  assign accept    = valid_out & ready_in;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sclk_q    <= 1'b0;
      ncs_q     <= 1'b1;
      armed     <= n_cs;
      skip_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      err       <= 1'b0;
    end else begin
      sclk_q <= spi_clk;
      ncs_q  <= n_cs;
      if (n_cs) begin
        armed <= 1'b1;
      end

      if (cs_rise) begin
        state    <= IDLE;
        skip_cnt <= '0;
        bit_cnt  <= '0;
        if ((state == DATA) && (bit_cnt != '0)) begin
          err <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              err       <= 1'b0;
              skip_cnt  <= '0;
              bit_cnt   <= '0;
              shift_reg <= '0;
              state     <= (SKIPBITS == 0) ? DATA : SKIP;
            end
          end
          SKIP: begin
            if (rise) begin
              skip_cnt <= skip_cnt + 1'b1;
              if (skip_cnt == SKIP_LAST) begin
                state <= DATA;
              end
            end
          end
          DATA: begin
            if (rise) begin
              shift_reg <= next_word[DATAW-2:0];
              bit_cnt   <= word_done ? '0 : bit_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end

      // Output buffer: a completing word either refills the slot or overflows.
      if (word_done) begin
        if (!valid_out || ready_in) begin
          data_out  <= next_word;
          valid_out <= 1'b1;
        end else begin
          err <= 1'b1;
        end
      end else if (accept) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_deserializer.sv
// Directed bench for spi_deserializer: table-driven transactions plus hand-written
// sequences for latency, overflow, simultaneous accept, skip abort and mid-word reset.
module tb_spi_deserializer;

  localparam int DATAW    = 8;
  localparam int SKIPBITS = 32;

  logic             clk;
  logic             rst;
  logic             n_cs;
  logic             spi_clk;
  logic             miso;
  logic [DATAW-1:0] data_out;
  logic             valid_out;
  logic             ready_in;
  logic             err;
  logic [1:0]       fsm_state;

  int checks   = 0;
  int failures = 0;
  int accepted = 0;
  logic [DATAW-1:0] exp_q[$];

  spi_deserializer #(.DATAW(DATAW), .SKIPBITS(SKIPBITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .n_cs      (n_cs),
    .spi_clk   (spi_clk),
    .miso      (miso),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .err       (err),
    .fsm_state (fsm_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] w0;
    logic [7:0] w1;
    int         nwords;
    int         trunc_bits;
    logic       exp_err;
  } vec_t;

  // Scoreboard: every accepted word must match the head of exp_q.
  always @(negedge clk) begin
    if (!rst && valid_out && ready_in) begin
      logic [DATAW-1:0] exp;
      accepted++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL word_unexpected got=%h", data_out);
      end else begin
        exp = exp_q.pop_front();
        if (data_out !== exp) begin
          failures++;
          $display("FAIL word_data got=%h want=%h", data_out, exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after a rising clk edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sclk_low(input logic b);
    miso    = b;
    spi_clk = 1'b0;
    tick(2);
  endtask

  task automatic send_bit(input logic b);
    sclk_low(b);
    spi_clk = 1'b1;
    tick(2);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_skip(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
  endtask

  task automatic cs_start();
    n_cs = 1'b0;
    tick(2);
  endtask

  task automatic cs_end();
    spi_clk = 1'b0;
    tick(2);
    n_cs = 1'b1;
    tick(2);
  endtask

  vec_t vecs[6];
  int   acc0;

  initial begin
    vecs[0] = '{8'hA5, 8'h3C, 2, 0, 1'b0};
    vecs[1] = '{8'h5A, 8'h00, 1, 0, 1'b0};
    vecs[2] = '{8'hFF, 8'h00, 1, 0, 1'b0};
    vecs[3] = '{8'h00, 8'h81, 2, 0, 1'b0};
    vecs[4] = '{8'hC3, 8'h00, 0, 5, 1'b1};
    vecs[5] = '{8'h5A, 8'h00, 1, 0, 1'b0};

    rst = 1'b1; n_cs = 1'b1; spi_clk = 1'b0; miso = 1'b0; ready_in = 1'b0;
    tick(3);
    @(negedge clk);
    check("rst_data", data_out, 0);
    check("rst_valid", valid_out, 0);
    check("rst_err", err, 0);
    check("rst_state", fsm_state, 0);
    tick(1);
    rst = 1'b0;
    tick(2);

    // Nominal transaction with latency check on the 8th rise of 0xA5
    ready_in = 1'b1;
    acc0 = accepted;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    cs_start();
    check("t1_state_skip", fsm_state, 1);
    send_skip(SKIPBITS);
    check("t1_state_data", fsm_state, 2);
    for (int i = 7; i >= 1; i--) send_bit(logic'(8'hA5 >> i));
    sclk_low(1'b1);
    spi_clk = 1'b1;
    @(negedge clk);
    check("t1_valid_before", valid_out, 0);
    tick(1);
    @(negedge clk);
    check("t1_valid_after", valid_out, 1);
    check("t1_data_after", data_out, 8'hA5);
    tick(1);
    send_word(8'h3C);
    cs_end();
    check("t1_err", err, 0);
    check("t1_words", accepted - acc0, 2);

    // Table of whole transactions with ready_in=1
    for (int v = 0; v < 6; v++) begin
      acc0 = accepted;
      if (vecs[v].nwords > 0) exp_q.push_back(vecs[v].w0);
      if (vecs[v].nwords > 1) exp_q.push_back(vecs[v].w1);
      cs_start();
      check($sformatf("v%0d_err_cleared", v), err, 0);
      send_skip(SKIPBITS);
      if (vecs[v].nwords > 0) send_word(vecs[v].w0);
      if (vecs[v].nwords > 1) send_word(vecs[v].w1);
      for (int b = 0; b < vecs[v].trunc_bits; b++) send_bit(vecs[v].w0[7-b]);
      cs_end();
      check($sformatf("v%0d_err", v), err, vecs[v].exp_err);
      check($sformatf("v%0d_words", v), accepted - acc0, vecs[v].nwords);
      check($sformatf("v%0d_valid_idle", v), valid_out, 0);
    end

    // Backpressure / overflow
    ready_in = 1'b0;
    acc0 = accepted;
    cs_start();
    send_skip(SKIPBITS);
    send_word(8'h11);
    @(negedge clk);
    check("t2_valid_11", valid_out, 1);
    check("t2_data_11", data_out, 8'h11);
    check("t2_err_11", err, 0);
    send_word(8'h22);
    @(negedge clk);
    check("t2_err_22", err, 1);
    check("t2_data_22", data_out, 8'h11);
    send_word(8'h33);
    cs_end();
    check("t2_data_33", data_out, 8'h11);
    check("t2_valid_held", valid_out, 1);
    exp_q.push_back(8'h11);
    ready_in = 1'b1;
    tick(1);
    @(negedge clk);
    check("t2_valid_drained", valid_out, 0);
    check("t2_words", accepted - acc0, 1);
    check("t2_err_sticky", err, 1);

    // Simultaneous accept and new word
    ready_in = 1'b0;
    acc0 = accepted;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    cs_start();
    send_skip(SKIPBITS);
    send_word(8'h11);
    for (int i = 7; i >= 1; i--) send_bit(logic'(8'h22 >> i));
    sclk_low(1'b0);
    spi_clk  = 1'b1;
    ready_in = 1'b1;
    tick(1);
    ready_in = 1'b0;
    @(negedge clk);
    check("t3_valid", valid_out, 1);
    check("t3_data", data_out, 8'h22);
    check("t3_err", err, 0);
    tick(1);
    cs_end();
    ready_in = 1'b1;
    tick(1);
    @(negedge clk);
    check("t3_words", accepted - acc0, 2);
    check("t3_queue_empty", exp_q.size(), 0);

    // Abort during skip phase
    acc0 = accepted;
    cs_start();
    send_skip(20);
    cs_end();
    check("t5_words", accepted - acc0, 0);
    check("t5_err", err, 0);
    check("t5_state", fsm_state, 0);

    // Reset mid-word, then edges with n_cs still low must be ignored
    acc0 = accepted;
    cs_start();
    send_skip(SKIPBITS);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check("t6_valid", valid_out, 0);
    check("t6_data", data_out, 0);
    check("t6_err", err, 0);
    check("t6_state", fsm_state, 0);
    send_skip(SKIPBITS + 16);
    check("t6_no_words", accepted - acc0, 0);
    check("t6_state_still_idle", fsm_state, 0);
    cs_end();
    exp_q.push_back(8'h5A);
    cs_start();
    send_skip(SKIPBITS);
    send_word(8'h5A);
    cs_end();
    check("t6_words_after", accepted - acc0, 1);
    check("t6_err_after", err, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
